// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer owning the PC, one outstanding word request
//
// Purpose: issues instruction fetches over a req/ready address handshake with
// an rvalid response, holds the fetched word for decode under stall, and
// applies branch/jump redirects while discarding any stale in-flight response.
//
// Ports:
//   i_clk, i_arst              clock, asynchronous active-low reset
//   i_redirect, i_redirect_pc  redirect request and target (low 2 bits ignored)
//   i_stall                    decode cannot accept the presented instruction
//   o_mem_req, o_mem_addr      request valid and word address
//   i_mem_ready                memory accepts the request this cycle
//   i_mem_rvalid, i_mem_rdata  response valid and instruction word
//   o_instr_valid              o_instruction / o_pc / o_pc_plus4 valid for decode
//   o_instruction, o_pc        fetched word and its PC
//   o_pc_plus4                 o_pc + 4, wrapping
module fetch_ctrl #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_stall,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_ready,
  input  logic                   i_mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_drop;   // outstanding response belongs to an abandoned PC
  logic [INSTR_WIDTH-1:0] r_instr;

  logic [ADDR_WIDTH-1:0]  w_target;
  logic [ADDR_WIDTH-1:0]  w_pc_plus4;

  assign w_target   = i_redirect_pc & ~ADDR_WIDTH'(3);
  assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_redirect) r_pc <= w_target;
          r_state <= S_REQ;
        end
        S_REQ: begin
          // A request accepted in the same cycle as a redirect fetches the
          // old PC; remember to throw its response away.
          if (i_redirect) r_pc <= w_target;
          if (i_mem_ready) begin
            r_state <= S_WAIT;
            r_drop  <= i_redirect;
          end
        end
        S_WAIT: begin
          if (i_redirect) begin
            r_pc <= w_target;
            if (i_mem_rvalid) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop  <= 1'b1;
            end
          end else if (i_mem_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_instr <= i_mem_rdata;
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          // Redirect wins over stall: the held instruction is on a dead path.
          if (i_redirect) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (!i_stall) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req     = (r_state == S_REQ);
  assign o_instr_valid = (r_state == S_OUT);
  assign o_mem_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_instruction = r_instr;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC datapath and a handshaked instruction memory or cache. It owns the program counter and issues one word request at a time with a req/ready address handshake and an rvalid response. It holds the fetched instruction for decode under stall, and applies branch/jump redirects, discarding any in-flight stale response. It replaces the fixed-latency PC-register/memory pairing in the fetch stage once the memory becomes multi-cycle.

## Interface
- ADDR_WIDTH, 64, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0)

- i_clk  in  1  clock, all state updates on rising edge
- i_arst  in  1  asynchronous, active-low reset
- i_redirect  in  1  redirect request from execute (taken branch/jump)
- i_redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] forced to 0 internally
- i_stall  in  1  decode cannot accept the presented instruction
- o_mem_req  out  1  memory request valid
- o_mem_addr  out  ADDR_WIDTH  request word address (= internal PC)
- i_mem_ready  in  1  memory accepts request this cycle (sampled only with o_mem_req)
- i_mem_rvalid  in  1  response data valid
- i_mem_rdata  in  INSTR_WIDTH  response instruction word
- o_instr_valid  out  1  o_instruction/o_pc valid for decode
- o_instruction  out  INSTR_WIDTH  fetched instruction
- o_pc  out  ADDR_WIDTH  PC of o_instruction (= internal PC)
- o_pc_plus4  out  ADDR_WIDTH  o_pc + 4, modulo 2^ADDR_WIDTH

## Operation
- Single PC register pc_q drives o_mem_addr and o_pc; o_pc_plus4 = pc_q + 4 (wraps, no carry out).
- At most one outstanding memory request.
- States: IDLE, REQ, WAIT, OUT; discard flag drop_q.
- IDLE: first cycle after reset release; o_mem_req=0; -> REQ.
- REQ: o_mem_req=1.
  - o_mem_addr may change while unaccepted; the memory samples the address only on o_mem_req & i_mem_ready.
  - Redirect without ready: pc_q <= redirect target; stay REQ.
  - Ready without redirect: -> WAIT, drop_q=0.
  - Ready and redirect in the same cycle: the accepted request is stale. pc_q <= target; -> WAIT with drop_q=1.
- WAIT: o_mem_req=0.
  - On i_mem_rvalid with drop_q=0: o_instruction <= i_mem_rdata; -> OUT.
  - On i_mem_rvalid with drop_q=1: data ignored; drop_q <= 0; -> REQ.
  - Redirect in WAIT, with or without rvalid: pc_q <= target; drop_q <= 1 if rvalid absent, else -> REQ directly.
- OUT: o_instr_valid=1; o_instruction and o_pc held stable.
  - Redirect, which has priority over stall: o_instr_valid drops next cycle; pc_q <= target; -> REQ.
  - Else i_stall=1: hold.
  - Else: pc_q <= pc_q + 4; -> REQ.
- i_mem_rvalid outside WAIT is ignored.
- i_mem_ready outside REQ is ignored.
- Async reset asserted mid-operation: immediate return to reset values. The state machine does not track an outstanding request after reset; a response arriving later is ignored because the FSM is not in WAIT.

## Timing
- Reset values: state=IDLE, pc_q=RESET_PC, drop_q=0, o_mem_req=0, o_mem_addr=RESET_PC, o_instr_valid=0, o_instruction=0, o_pc=RESET_PC, o_pc_plus4=RESET_PC+4.
- o_mem_req and o_instr_valid are decoded from registered state only. There is no combinational path from inputs to outputs.
- Accept at edge n (REQ & ready); earliest rvalid in cycle n+1; o_instr_valid=1 from the cycle after the rvalid edge.
- Zero-wait memory with no stall gives 1 instruction per 3 cycles (REQ, WAIT, OUT).
- Redirect takes effect at the next edge. The first request to the target appears the cycle after the redirect, or after the stale response is drained.

## Test plan
- Reset with RESET_PC=0x100, release, ready=1, rvalid 1 cycle after accept with data 0x00A00093 -> o_mem_addr=0x100 in REQ; o_instr_valid=1 with o_instruction=0x00A00093, o_pc=0x100, o_pc_plus4=0x104; next request at 0x104.
- Same sequence with i_stall=1 for 4 cycles in OUT -> instruction/pc held 4 cycles, o_mem_req=0; request 0x104 issued the cycle after stall drops.
- Redirect to 0x2000 while in WAIT before rvalid -> the response for the old PC is dropped (o_instr_valid stays 0); next o_mem_addr=0x2000; delivered o_pc=0x2000.
- Redirect to 0x3003 in the same cycle as accept -> stale response dropped; request at 0x3000.
- Redirect and i_stall both high in OUT -> o_instr_valid=0 next cycle; request at target.
- Assert i_arst low while in WAIT, release, then an rvalid pulse arrives in IDLE -> ignored; fetch restarts at RESET_PC.
- pc_q=0xFFFF_FFFF_FFFF_FFFC delivered -> o_pc_plus4=0; next fetch address 0.
